// File: rtl/dsp_be_cfg_sync.sv
// dsp_be_cfg_sync
// Moves scan-domain configuration and status traffic into the i_clk domain
// and sequences the per-channel BERT/EQ resets.
//   - Config commit: a toggle on i_cfg_upd_tgl loads i_cfg_wr into o_cfg.
//     The wide config bus itself is never synchronized. It is quasi-static
//     and is sampled only on the commit edge, after the toggle has settled.
//   - Status snapshot: a toggle on i_snap_req_tgl captures i_stat into o_stat,
//     and o_snap_ack_tgl flips to acknowledge the capture.
//   - Reset sequencer: channel resets are asserted immediately on request.
//     Once all requests have dropped, the channels are released in ascending
//     order, RstGapCycles apart.
//
// Ports
//   i_clk          core clock (the only clock)
//   i_rstb         asynchronous active-low reset
//   i_cfg_wr       scan config word, asynchronous, quasi-static
//   i_cfg_upd_tgl  commit request toggle, asynchronous
//   o_cfg          committed config
//   o_cfg_commit   one-cycle pulse on each commit
//   i_snap_req_tgl snapshot request toggle, asynchronous
//   i_stat         live per-channel counters
//   o_stat         captured snapshot
//   o_snap_ack_tgl flips once per completed capture
//   i_rst_req      per-channel reset request levels, asynchronous
//   o_rst_ch       sequenced active-high channel resets
//   o_busy         sequencer is not in IDLE
//
// Reset sequencer states
//   state | meaning
//   IDLE  | all requested channels released; waiting for a request
//   HOLD  | at least one request active; channels held in reset
//   SEQ   | releasing channels idx = 0..NumCh-1, with gap cycles between releases
module dsp_be_cfg_sync #(
  parameter int CfgWidth     = 256,
  parameter int StatWidth    = 64,
  parameter int NumCh        = 4,
  parameter int SyncStages   = 2,
  parameter int RstGapCycles = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstb,
  input  logic [CfgWidth-1:0]        i_cfg_wr,
  input  logic                       i_cfg_upd_tgl,
  output logic [CfgWidth-1:0]        o_cfg,
  output logic                       o_cfg_commit,
  input  logic                       i_snap_req_tgl,
  input  logic [NumCh*StatWidth-1:0] i_stat,
  output logic [NumCh*StatWidth-1:0] o_stat,
  output logic                       o_snap_ack_tgl,
  input  logic [NumCh-1:0]           i_rst_req,
  output logic [NumCh-1:0]           o_rst_ch,
  output logic                       o_busy
);

  // idx runs one past the last channel. That extra value is the
  // "all processed" step, which leaves SEQ one cycle after the last release.
  localparam int IdxW = $clog2(NumCh + 1);
  localparam int GapW = (RstGapCycles > 1) ? $clog2(RstGapCycles) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumCh - 1);
  localparam logic [IdxW-1:0] IdxDone = IdxW'(NumCh);
  localparam logic [GapW-1:0] GapLoad = GapW'(RstGapCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SEQ  = 2'd2
  } state_e;

  logic [SyncStages-1:0]            cfg_sync_q, cfg_sync_d;
  logic [SyncStages-1:0]            snap_sync_q, snap_sync_d;
  logic [SyncStages-1:0][NumCh-1:0] req_sync_q, req_sync_d;
  logic                             cfg_prev_q, cfg_prev_d;
  logic                             snap_prev_q, snap_prev_d;

  logic [CfgWidth-1:0]              cfg_q, cfg_d;
  logic                             commit_q, commit_d;
  logic [NumCh*StatWidth-1:0]       stat_q, stat_d;
  logic                             ack_q, ack_d;

  state_e                           state_q, state_d;
  logic [IdxW-1:0]                  idx_q, idx_d;
  logic [GapW-1:0]                  gap_q, gap_d;
  logic [NumCh-1:0]                 rst_ch_q, rst_ch_d;

  logic                             cfg_evt, snap_evt;
  logic [NumCh-1:0]                 req_s;
  logic [NumCh-1:0]                 idx_oh;

  assign req_s    = req_sync_q[SyncStages-1];
  assign cfg_evt  = cfg_sync_q[SyncStages-1] ^ cfg_prev_q;
  assign snap_evt = snap_sync_q[SyncStages-1] ^ snap_prev_q;
  // When idx equals IdxDone, idx_oh is all zeros, so no channel can be released.
  assign idx_oh   = NumCh'(1) << idx_q;

  // Synchronizers, edge detectors and the commit/snapshot datapath.
  always_comb begin
    cfg_sync_d  = {cfg_sync_q[SyncStages-2:0], i_cfg_upd_tgl};
    snap_sync_d = {snap_sync_q[SyncStages-2:0], i_snap_req_tgl};
    req_sync_d  = {req_sync_q[SyncStages-2:0], i_rst_req};
    cfg_prev_d  = cfg_sync_q[SyncStages-1];
    snap_prev_d = snap_sync_q[SyncStages-1];
    cfg_d       = cfg_evt ? i_cfg_wr : cfg_q;
    commit_d    = cfg_evt;
    stat_d      = snap_evt ? i_stat : stat_q;
    ack_d       = ack_q ^ snap_evt;
  end

  // State register (also holds all other flops).
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      cfg_sync_q  <= '0;
      snap_sync_q <= '0;
      req_sync_q  <= '0;
      cfg_prev_q  <= 1'b0;
      snap_prev_q <= 1'b0;
      cfg_q       <= '0;
      commit_q    <= 1'b0;
      stat_q      <= '0;
      ack_q       <= 1'b0;
      state_q     <= ST_HOLD;
      idx_q       <= '0;
      gap_q       <= '0;
      rst_ch_q    <= '1;
    end else begin
      cfg_sync_q  <= cfg_sync_d;
      snap_sync_q <= snap_sync_d;
      req_sync_q  <= req_sync_d;
      cfg_prev_q  <= cfg_prev_d;
      snap_prev_q <= snap_prev_d;
      cfg_q       <= cfg_d;
      commit_q    <= commit_d;
      stat_q      <= stat_d;
      ack_q       <= ack_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      rst_ch_q    <= rst_ch_d;
    end
  end

  // Next-state logic for the reset sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    rst_ch_d = rst_ch_q | req_s;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!(|req_s)) begin
          state_d = ST_SEQ;
          idx_d   = '0;
          gap_d   = '0;
        end
      end
      ST_SEQ: begin
        // SEQ is entered only with every request low, so any request seen
        // here is a new rise and aborts the sequence.
        if (|req_s) begin
          state_d = ST_HOLD;
        end else if (idx_q == IdxDone) begin
          state_d = ST_IDLE;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GapW'(1);
          // Advance idx as the gap expires, so releases land exactly
          // RstGapCycles apart.
          if (gap_q == GapW'(1)) idx_d = idx_q + IdxW'(1);
        end else if (|(rst_ch_q & idx_oh)) begin
          rst_ch_d = rst_ch_q & ~idx_oh;
          // No gap after the last channel: leave SEQ on the next edge.
          if (idx_q == IdxLast || RstGapCycles == 1) idx_d = idx_q + IdxW'(1);
          else gap_d = GapLoad;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Output logic.
  always_comb begin
    o_busy         = (state_q != ST_IDLE);
    o_rst_ch       = rst_ch_q;
    o_cfg          = cfg_q;
    o_cfg_commit   = commit_q;
    o_stat         = stat_q;
    o_snap_ack_tgl = ack_q;
  end

endmodule

// File: tb/tb_dsp_be_cfg_sync.sv
module tb_dsp_be_cfg_sync;

  localparam int CfgW  = 16;
  localparam int StatW = 8;
  localparam int NCh   = 4;

  logic              clk = 1'b0;
  logic              rstb;
  logic [CfgW-1:0]   cfg_wr;
  logic              cfg_tgl;
  logic [CfgW-1:0]   cfg;
  logic              commit;
  logic              snap_tgl;
  logic [NCh*StatW-1:0] stat_in;
  logic [NCh*StatW-1:0] stat_out;
  logic              ack;
  logic [NCh-1:0]    rst_req;
  logic [NCh-1:0]    rst_ch;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_be_cfg_sync #(
    .CfgWidth(CfgW), .StatWidth(StatW), .NumCh(NCh),
    .SyncStages(2), .RstGapCycles(3)
  ) dut (
    .i_clk(clk), .i_rstb(rstb),
    .i_cfg_wr(cfg_wr), .i_cfg_upd_tgl(cfg_tgl),
    .o_cfg(cfg), .o_cfg_commit(commit),
    .i_snap_req_tgl(snap_tgl), .i_stat(stat_in),
    .o_stat(stat_out), .o_snap_ack_tgl(ack),
    .i_rst_req(rst_req), .o_rst_ch(rst_ch), .o_busy(busy)
  );

  typedef struct {
    logic [3:0] rst;
    logic       busy;
  } seq_vec_t;

  typedef struct {
    logic [15:0] cfg_wr;
    logic [31:0] stat;
    logic        flip_cfg;
    logic        flip_snap;
    logic [15:0] exp_cfg;
    logic [31:0] exp_stat;
    logic        exp_ack;
  } cs_vec_t;

  seq_vec_t seq_tbl[12];
  cs_vec_t  cs_tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_seq_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("%s_rst_e%0d", tag, i + 1), 64'(rst_ch), 64'(seq_tbl[i].rst));
      check($sformatf("%s_busy_e%0d", tag, i + 1), 64'(busy), 64'(seq_tbl[i].busy));
    end
  endtask

  logic [15:0] prev_cfg;
  logic [31:0] prev_stat;

  initial begin
    // Reset release with all requests low: releases at edges 2, 5, 8 and 11;
    // busy falls at edge 12.
    seq_tbl[0]  = '{4'b1111, 1'b1};
    seq_tbl[1]  = '{4'b1110, 1'b1};
    seq_tbl[2]  = '{4'b1110, 1'b1};
    seq_tbl[3]  = '{4'b1110, 1'b1};
    seq_tbl[4]  = '{4'b1100, 1'b1};
    seq_tbl[5]  = '{4'b1100, 1'b1};
    seq_tbl[6]  = '{4'b1100, 1'b1};
    seq_tbl[7]  = '{4'b1000, 1'b1};
    seq_tbl[8]  = '{4'b1000, 1'b1};
    seq_tbl[9]  = '{4'b1000, 1'b1};
    seq_tbl[10] = '{4'b0000, 1'b1};
    seq_tbl[11] = '{4'b0000, 1'b0};

    cs_tbl[0] = '{16'hA5C3, 32'h44332211, 1'b1, 1'b0, 16'hA5C3, 32'h00000000, 1'b0};
    cs_tbl[1] = '{16'h1234, 32'h44332211, 1'b0, 1'b1, 16'hA5C3, 32'h44332211, 1'b1};
    cs_tbl[2] = '{16'h0F0F, 32'hDEADBEEF, 1'b1, 1'b1, 16'h0F0F, 32'hDEADBEEF, 1'b0};
    cs_tbl[3] = '{16'hFFFF, 32'h01020304, 1'b0, 1'b0, 16'h0F0F, 32'hDEADBEEF, 1'b0};
    cs_tbl[4] = '{16'h8001, 32'h80000001, 1'b1, 1'b1, 16'h8001, 32'h80000001, 1'b1};

    rstb = 1'b0; cfg_wr = '0; cfg_tgl = 1'b0; snap_tgl = 1'b0;
    stat_in = '0; rst_req = '0;
    #12;
    check("rst_rst_ch", 64'(rst_ch), 64'hF);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_cfg", 64'(cfg), 64'd0);
    check("rst_commit", 64'(commit), 64'd0);
    check("rst_stat", 64'(stat_out), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);

    // Power-up release sequence.
    @(negedge clk);
    rstb = 1'b1;
    run_seq_table("pwr");

    // Commit / snapshot vectors.
    prev_cfg = 16'h0;
    prev_stat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      cfg_wr = cs_tbl[i].cfg_wr;
      stat_in = cs_tbl[i].stat;
      if (cs_tbl[i].flip_cfg) cfg_tgl = ~cfg_tgl;
      if (cs_tbl[i].flip_snap) snap_tgl = ~snap_tgl;
      for (int e = 1; e <= 2; e++) begin
        step();
        check($sformatf("v%0d_cfg_e%0d", i, e), 64'(cfg), 64'(prev_cfg));
        check($sformatf("v%0d_commit_e%0d", i, e), 64'(commit), 64'd0);
        check($sformatf("v%0d_stat_e%0d", i, e), 64'(stat_out), 64'(prev_stat));
      end
      step();
      check($sformatf("v%0d_cfg_e3", i), 64'(cfg), 64'(cs_tbl[i].exp_cfg));
      check($sformatf("v%0d_commit_e3", i), 64'(commit), 64'(cs_tbl[i].flip_cfg));
      check($sformatf("v%0d_stat_e3", i), 64'(stat_out), 64'(cs_tbl[i].exp_stat));
      check($sformatf("v%0d_ack_e3", i), 64'(ack), 64'(cs_tbl[i].exp_ack));
      // Disturb the live inputs; the captured outputs must hold.
      stat_in = '0;
      cfg_wr = ~cs_tbl[i].cfg_wr;
      step();
      check($sformatf("v%0d_commit_e4", i), 64'(commit), 64'd0);
      step();
      step();
      check($sformatf("v%0d_cfg_hold", i), 64'(cfg), 64'(cs_tbl[i].exp_cfg));
      check($sformatf("v%0d_stat_hold", i), 64'(stat_out), 64'(cs_tbl[i].exp_stat));
      check($sformatf("v%0d_ack_hold", i), 64'(ack), 64'(cs_tbl[i].exp_ack));
      prev_cfg = cs_tbl[i].exp_cfg;
      prev_stat = cs_tbl[i].exp_stat;
    end

    // Double flip between two edges: the net change is zero, so no commit.
    cfg_wr = 16'h5555;
    cfg_tgl = ~cfg_tgl;
    #2;
    cfg_tgl = ~cfg_tgl;
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("dbl_commit_e%0d", e), 64'(commit), 64'd0);
    end
    check("dbl_cfg", 64'(cfg), 64'h8001);

    // Request all channels from IDLE, then drop the requests; reset mid-SEQ.
    rst_req = 4'b1111;
    for (int e = 0; e < 4; e++) step();
    check("req_all_rst", 64'(rst_ch), 64'hF);
    check("req_all_busy", 64'(busy), 64'd1);
    rst_req = 4'b0000;
    for (int e = 0; e < 3; e++) step();
    check("req_drop_e3", 64'(rst_ch), 64'hF);
    step();
    check("req_drop_e4", 64'(rst_ch), 64'hE);
    step();
    #2;
    rstb = 1'b0;
    #1;
    check("async_rst_ch", 64'(rst_ch), 64'hF);
    check("async_stat", 64'(stat_out), 64'd0);
    check("async_cfg", 64'(cfg), 64'd0);
    check("async_busy", 64'(busy), 64'd1);

    // Abort: a request for channel 2 arrives after channel 0 has been released.
    @(negedge clk);
    rstb = 1'b1;
    step();
    step();
    check("abort_ch0_rel", 64'(rst_ch), 64'hE);
    rst_req = 4'b0100;
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("abort_rst_e%0d", e), 64'(rst_ch), 64'hE);
      check($sformatf("abort_busy_e%0d", e), 64'(busy), 64'd1);
    end
    rst_req = 4'b0000;
    // After the drop: 2 sync edges, HOLD->SEQ, skip ch0, then release
    // ch1/ch2/ch3 at drop edges 5, 8 and 11; IDLE at drop edge 12.
    seq_tbl[0]  = '{4'b1110, 1'b1};
    seq_tbl[1]  = '{4'b1110, 1'b1};
    seq_tbl[2]  = '{4'b1110, 1'b1};
    seq_tbl[3]  = '{4'b1110, 1'b1};
    run_seq_table("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dsp_be_cfg_sync.md
DSP_BE_CFG_SYNC -- requirements
Module: dsp_be_cfg_sync

Parameters
REQ-001 The block SHALL have parameter CfgWidth, default 256: width of the scan-written config word.
REQ-002 The block SHALL have parameter StatWidth, default 64: readout bits per channel.
REQ-003 The block SHALL have parameter NumCh, default 4: number of BERT/EQ channels; legal range 1..16.
REQ-004 The block SHALL have parameter SyncStages, default 2: synchronizer depth; legal range 2..4.
REQ-005 The block SHALL have parameter RstGapCycles, default 8: clk cycles between successive channel reset releases; legal range 1..255.

Interface
REQ-006 The block SHALL have port i_clk, input, 1 bit: core clock; the block's only clock.
REQ-007 The block SHALL have port i_rstb, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port i_cfg_wr, input, CfgWidth bits: scan config, quasi-static, asynchronous to i_clk.
REQ-009 The block SHALL have port i_cfg_upd_tgl, input, 1 bit: scan-domain toggle requesting a config commit.
REQ-010 The block SHALL have port o_cfg, output, CfgWidth bits: committed config, glitch-free in the i_clk domain.
REQ-011 The block SHALL have port o_cfg_commit, output, 1 bit: one-cycle pulse marking a commit.
REQ-012 The block SHALL have port i_snap_req_tgl, input, 1 bit: scan-domain toggle requesting a status snapshot.
REQ-013 The block SHALL have port i_stat, input, NumCh*StatWidth bits: live per-channel BERT counters.
REQ-014 The block SHALL have port o_stat, output, NumCh*StatWidth bits: captured snapshot for scan readout.
REQ-015 The block SHALL have port o_snap_ack_tgl, output, 1 bit: toggles once per completed capture.
REQ-016 The block SHALL have port i_rst_req, input, NumCh bits: per-channel reset request levels, asynchronous.
REQ-017 The block SHALL have port o_rst_ch, output, NumCh bits: sequenced active-high channel resets.
REQ-018 The block SHALL have port o_busy, output, 1 bit: high while the reset sequencer is not in IDLE.

Function
REQ-019 i_cfg_upd_tgl, i_snap_req_tgl and each i_rst_req bit SHALL each pass through SyncStages flops; no other i_cfg_wr path SHALL cross domains except through a commit.
REQ-020 An event SHALL be detected when a synchronized toggle differs from its registered previous value.
REQ-021 On a commit event, o_cfg SHALL load i_cfg_wr and o_cfg_commit SHALL pulse for exactly 1 cycle; latency from the toggle settling SHALL be SyncStages+1 rising edges.
REQ-022 On a snapshot event, o_stat SHALL load all NumCh*StatWidth bits of i_stat on the same edge, and o_snap_ack_tgl SHALL invert on that edge; latency SHALL be SyncStages+1 edges.
REQ-023 Between events, o_cfg and o_stat SHALL hold their values.
REQ-024 Simultaneous commit and snapshot events SHALL both complete on the same edge, independently.
REQ-025 If a toggle flips again before its previous event is detected, only the net change SHALL be seen (an even count of flips yields no event); this behaviour is legal.
REQ-026 The reset sequencer SHALL have the states IDLE, HOLD and SEQ, with a channel index idx and a gap counter.
REQ-027 In any state, a synchronized i_rst_req[k]=1 SHALL set o_rst_ch[k]=1 on the next edge.
REQ-028 IDLE: if any synchronized request is 1, the sequencer SHALL go to HOLD.
REQ-029 HOLD: when all synchronized requests are 0, the sequencer SHALL go to SEQ with idx=0 and gap=0.
REQ-030 SEQ: when gap==0, the sequencer SHALL clear o_rst_ch[idx] if it is set; otherwise it SHALL skip that idx in 1 cycle without a gap.
REQ-031 SEQ: after a release, gap SHALL load RstGapCycles-1 and count down to 0; idx SHALL then increment.
REQ-032 SEQ: after idx reaches NumCh-1 and is processed, the sequencer SHALL go to IDLE.
REQ-033 In SEQ, any synchronized request rising SHALL abort to HOLD; channels already released and not re-requested SHALL stay released.
REQ-034 o_busy SHALL be 1 when the state is not IDLE.
REQ-035 Counter widths SHALL be clog2-sized, and gap SHALL never wrap below 0.

Reset
REQ-036 When i_rstb=0, asynchronously: o_cfg=0, o_cfg_commit=0, o_stat=0, o_snap_ack_tgl=0, o_rst_ch=all 1s, state=HOLD, o_busy=1, synchronizers and edge registers=0.
REQ-037 After reset deassertion with all i_rst_req=0, the sequencer SHALL run SEQ and release the channels in ascending order.
REQ-038 Reset mid-sequence SHALL return all channels to the asserted state immediately.

Verification (SyncStages=2, NumCh=4, RstGapCycles=3, CfgWidth=16, StatWidth=8)
REQ-039 Release reset with i_rst_req=0 -> o_rst_ch goes 1111->1110->1100->1000->0000, 3 cycles apart; o_busy falls 1 cycle after the last release.
REQ-040 i_cfg_wr=0xA5C3, flip i_cfg_upd_tgl -> o_cfg=0xA5C3 and o_cfg_commit pulses exactly on edge 3; o_cfg is unchanged on edges 1-2.
REQ-041 i_stat=0x44332211, flip i_snap_req_tgl, then change i_stat to 0 -> o_stat=0x44332211 holds and o_snap_ack_tgl=1.
REQ-042 Flip both toggles on the same cycle -> commit and capture occur on the same edge.
REQ-043 During SEQ after channel 0 is released, raise i_rst_req[2] -> o_rst_ch[2] stays 1, state goes to HOLD, channel 0 stays 0; after the request drops, channels 1-3 release in order.
REQ-044 Pull i_rstb low mid-SEQ -> o_rst_ch=1111 and o_stat=0 asynchronously, with no clock edge required.
